// File: rtl/lsu_pkg.sv
// Shared LSU types, funct3 encodings and size/alignment/legality helpers.
package lsu_pkg;

    localparam logic [2:0] FUNCT3_LB  = 3'b000;
    localparam logic [2:0] FUNCT3_LH  = 3'b001;
    localparam logic [2:0] FUNCT3_LW  = 3'b010;
    localparam logic [2:0] FUNCT3_LBU = 3'b100;
    localparam logic [2:0] FUNCT3_LHU = 3'b101;
    localparam logic [2:0] FUNCT3_SB  = 3'b000;
    localparam logic [2:0] FUNCT3_SH  = 3'b001;
    localparam logic [2:0] FUNCT3_SW  = 3'b010;

    typedef enum logic [1:0] {IDLE, ACCESS, SPLIT, DONE} lsu_state_e;

    // Size is carried in funct3[1:0] for both loads and stores.
    function automatic logic [2:0] access_bytes(input logic [2:0] funct3);
        case (funct3[1:0])
            2'b00:   return 3'd1;
            2'b01:   return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

    function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] addr_lo);
        case (funct3[1:0])
            2'b01:   return addr_lo[0];
            2'b10:   return addr_lo != 2'b00;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic is_illegal(input logic is_store, input logic [2:0] funct3);
        if (is_store)
            return funct3[2] || (funct3[1:0] == 2'b11);
        return (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
    endfunction

endpackage

// File: rtl/lsu_load_extend.sv
// Extends a reassembled split-load buffer: LH sign-extends, LHU zero-extends, LW passes through.
// Purely combinational, no backpressure.
module lsu_load_extend
    import lsu_pkg::*;
(
    input  logic [31:0] data_buf,
    input  logic [2:0]  funct3,
    output logic [31:0] data_ext
);

    always_comb begin
        data_ext = data_buf;
        case (funct3)
            FUNCT3_LH:  data_ext = {{16{data_buf[15]}}, data_buf[15:0]};
            FUNCT3_LHU: data_ext = {16'h0000, data_buf[15:0]};
            default:    ;
        endcase
    end

endmodule

// File: rtl/lsu_access_sequencer.sv
// Load/store sequencer to byte memory; aligned ops take one memory cycle, misaligned ones N byte cycles.
// Response at T+1 (error), T+2 (aligned), T+N+1 (split); req_ready_o is high only while IDLE.
module lsu_access_sequencer
    import lsu_pkg::*;
#(
    parameter int AWIDTH   = 32,
    parameter int DWIDTH   = 32,
    parameter bit SPLIT_EN = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic              req_is_store_i,
    input  logic [2:0]        req_funct3_i,
    input  logic [AWIDTH-1:0] req_addr_i,
    input  logic [DWIDTH-1:0] req_wdata_i,
    output logic              resp_valid_o,
    output logic [DWIDTH-1:0] resp_rdata_o,
    output logic              resp_err_o,
    output logic [AWIDTH-1:0] mem_addr_o,
    output logic [DWIDTH-1:0] mem_wdata_o,
    output logic              mem_read_en_o,
    output logic              mem_write_en_o,
    output logic [2:0]        mem_funct3_o,
    input  logic [DWIDTH-1:0] mem_rdata_i
);

    if (DWIDTH != 32) begin : g_dwidth_check
        $error("lsu_access_sequencer: only DWIDTH=32 is supported");
    end

    lsu_state_e        state_q, state_d;
    logic [AWIDTH-1:0] addr_q;
    logic [DWIDTH-1:0] wdata_q, rdata_q;
    logic [2:0]        funct3_q;
    logic              is_store_q, err_q;
    logic [1:0]        cnt_q;
    logic [31:0]       buf_q, buf_merged, ext_data;
    logic              req_mis, req_err, last_byte;
    logic [2:0]        nbytes;

    assign req_mis   = is_misaligned(req_funct3_i, req_addr_i[1:0]);
    assign req_err   = is_illegal(req_is_store_i, req_funct3_i) || (!SPLIT_EN && req_mis);
    assign nbytes    = access_bytes(funct3_q);
    assign last_byte = ({1'b0, cnt_q} == nbytes - 3'd1);

    // Buffer as it will look once the byte arriving this cycle is written in.
    always_comb begin
        buf_merged = buf_q;
        buf_merged[8*cnt_q +: 8] = mem_rdata_i[7:0];
    end

    lsu_load_extend u_load_extend (
        .data_buf (buf_merged),
        .funct3   (funct3_q),
        .data_ext (ext_data)
    );

    always_comb begin
        state_d        = state_q;
        req_ready_o    = 1'b0;
        resp_valid_o   = 1'b0;
        mem_addr_o     = '0;
        mem_wdata_o    = '0;
        mem_read_en_o  = 1'b0;
        mem_write_en_o = 1'b0;
        mem_funct3_o   = '0;
        case (state_q)
            IDLE: begin
                req_ready_o = 1'b1;
                if (req_valid_i) begin
                    if (req_err)      state_d = DONE;
                    else if (req_mis) state_d = SPLIT;
                    else              state_d = ACCESS;
                end
            end
            ACCESS: begin
                mem_addr_o     = addr_q;
                mem_funct3_o   = funct3_q;
                mem_wdata_o    = wdata_q;
                mem_write_en_o = is_store_q;
                mem_read_en_o  = !is_store_q;
                state_d        = DONE;
            end
            SPLIT: begin
                mem_addr_o     = addr_q + AWIDTH'(cnt_q);
                mem_funct3_o   = is_store_q ? FUNCT3_SB : FUNCT3_LBU;
                mem_wdata_o    = DWIDTH'(wdata_q[8*cnt_q +: 8]);
                mem_write_en_o = is_store_q;
                mem_read_en_o  = !is_store_q;
                if (last_byte) state_d = DONE;
            end
            DONE: begin
                resp_valid_o = 1'b1;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign resp_err_o   = (state_q == DONE) && err_q;
    assign resp_rdata_o = rdata_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            wdata_q    <= '0;
            funct3_q   <= '0;
            is_store_q <= 1'b0;
            err_q      <= 1'b0;
            cnt_q      <= '0;
            buf_q      <= '0;
            rdata_q    <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: if (req_valid_i) begin
                    addr_q     <= req_addr_i;
                    wdata_q    <= req_wdata_i;
                    funct3_q   <= req_funct3_i;
                    is_store_q <= req_is_store_i;
                    err_q      <= req_err;
                    cnt_q      <= '0;
                    buf_q      <= '0;
                    if (req_err) rdata_q <= '0;
                end
                // Memory already extends aligned loads, so the word is taken as-is.
                ACCESS: rdata_q <= is_store_q ? '0 : mem_rdata_i;
                SPLIT: begin
                    buf_q <= buf_merged;
                    cnt_q <= cnt_q + 2'd1;
                    if (last_byte) rdata_q <= is_store_q ? '0 : DWIDTH'(ext_data);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_access_sequencer.sv
// Bench for lsu_access_sequencer: byte memory model plus a transaction-level reference model.
module tb_lsu_access_sequencer;
    import lsu_pkg::*;

    localparam logic [31:0] BASE_ADDR = 32'h0100_0000;

    typedef struct packed {
        logic [31:0] addr;
        logic [2:0]  f3;
        logic        we;
        logic [31:0] wdata;
    } acc_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0, req_ready, req_is_store = 1'b0;
    logic [2:0]  req_funct3 = '0;
    logic [31:0] req_addr = '0, req_wdata = '0;
    logic        resp_valid, resp_err;
    logic [31:0] resp_rdata;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_read_en, mem_write_en;
    logic [2:0]  mem_funct3;

    logic        ns_valid = 1'b0, ns_ready, ns_resp_valid, ns_resp_err, ns_rd, ns_wr;
    logic [2:0]  ns_f3 = '0, ns_mem_f3;
    logic [31:0] ns_addr = '0, ns_rdata, ns_mem_addr, ns_mem_wdata;

    int errors = 0;
    int checks = 0;
    int resp_cnt = 0;

    logic [7:0] mem [256];
    logic [7:0] ref_mem [256];
    logic       pl_we = 1'b0;
    logic [7:0] pl_addr = '0, pl_dat = '0;
    logic [7:0] mo0, mo1, mo2, mo3;
    acc_t       acc_q[$];
    acc_t       exp_q[$];

    always #5 clk = ~clk;

    lsu_access_sequencer dut (
        .clk(clk), .rst(rst),
        .req_valid_i(req_valid), .req_ready_o(req_ready), .req_is_store_i(req_is_store),
        .req_funct3_i(req_funct3), .req_addr_i(req_addr), .req_wdata_i(req_wdata),
        .resp_valid_o(resp_valid), .resp_rdata_o(resp_rdata), .resp_err_o(resp_err),
        .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata), .mem_read_en_o(mem_read_en),
        .mem_write_en_o(mem_write_en), .mem_funct3_o(mem_funct3), .mem_rdata_i(mem_rdata)
    );

    lsu_access_sequencer #(.SPLIT_EN(1'b0)) dut_ns (
        .clk(clk), .rst(rst),
        .req_valid_i(ns_valid), .req_ready_o(ns_ready), .req_is_store_i(1'b0),
        .req_funct3_i(ns_f3), .req_addr_i(ns_addr), .req_wdata_i(32'h0),
        .resp_valid_o(ns_resp_valid), .resp_rdata_o(ns_rdata), .resp_err_o(ns_resp_err),
        .mem_addr_o(ns_mem_addr), .mem_wdata_o(ns_mem_wdata), .mem_read_en_o(ns_rd),
        .mem_write_en_o(ns_wr), .mem_funct3_o(ns_mem_f3), .mem_rdata_i(32'h5A5A_5A5A)
    );

    // Memory: combinational extending read, byte-lane write at the clock edge.
    assign mo0 = mem_addr[7:0];
    assign mo1 = mem_addr[7:0] + 8'd1;
    assign mo2 = mem_addr[7:0] + 8'd2;
    assign mo3 = mem_addr[7:0] + 8'd3;

    always_comb begin
        case (mem_funct3)
            FUNCT3_LB:  mem_rdata = {{24{mem[mo0][7]}}, mem[mo0]};
            FUNCT3_LBU: mem_rdata = {24'h0, mem[mo0]};
            FUNCT3_LH:  mem_rdata = {{16{mem[mo1][7]}}, mem[mo1], mem[mo0]};
            FUNCT3_LHU: mem_rdata = {16'h0, mem[mo1], mem[mo0]};
            default:    mem_rdata = {mem[mo3], mem[mo2], mem[mo1], mem[mo0]};
        endcase
    end

    always @(posedge clk) begin
        if (pl_we) mem[pl_addr] <= pl_dat;
        else if (mem_write_en) begin
            mem[mo0] <= mem_wdata[7:0];
            if (mem_funct3[1:0] != 2'b00) mem[mo1] <= mem_wdata[15:8];
            if (mem_funct3[1:0] == 2'b10) begin
                mem[mo2] <= mem_wdata[23:16];
                mem[mo3] <= mem_wdata[31:24];
            end
        end
    end

    always @(negedge clk) begin
        if (mem_read_en || mem_write_en) acc_q.push_back('{mem_addr, mem_funct3, mem_write_en, mem_wdata});
        if (resp_valid) resp_cnt <= resp_cnt + 1;
    end

    task automatic poke(input logic [7:0] a, input logic [7:0] d);
        @(negedge clk);
        pl_we = 1'b1; pl_addr = a; pl_dat = d; ref_mem[a] = d;
        @(posedge clk); #1;
        pl_we = 1'b0;
    endtask

    // Issues one request; lat counts cycles after the accepting edge (-1 if no response).
    task automatic run_op(input logic st, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                          output int lat, output logic [31:0] rd, output logic er, output int start);
        start = acc_q.size();
        lat = -1; rd = '0; er = 1'b0;
        @(negedge clk);
        req_valid = 1'b1; req_is_store = st; req_funct3 = f3; req_addr = a; req_wdata = wd;
        for (int i = 0; i < 20 && !req_ready; i++) @(negedge clk);
        @(posedge clk); #1;
        req_valid = 1'b0;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            if (resp_valid) begin
                lat = n; rd = resp_rdata; er = resp_err;
                break;
            end
        end
    endtask

    // Transaction-level reference: legality, size, alignment and byte-wise memory effect.
    task automatic model_op(input logic st, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                            output int lat, output logic [31:0] rd, output logic er);
        int n;
        logic legal;
        logic [31:0] val, sh;
        exp_q.delete();
        rd = '0; er = 1'b0; val = '0; lat = 1;
        if (st) legal = (f3 == FUNCT3_SB) || (f3 == FUNCT3_SH) || (f3 == FUNCT3_SW);
        else    legal = f3 inside {FUNCT3_LB, FUNCT3_LH, FUNCT3_LW, FUNCT3_LBU, FUNCT3_LHU};
        if (f3 == FUNCT3_LW) n = 4;
        else if (f3 == FUNCT3_LH || f3 == FUNCT3_LHU) n = 2;
        else n = 1;
        if (!legal) er = 1'b1;
        else begin
            if (a % n == 0) begin
                lat = 2;
                exp_q.push_back('{a, f3, st, wd});
            end else begin
                lat = n + 1;
                for (int k = 0; k < n; k++) begin
                    sh = wd >> (8 * k);
                    exp_q.push_back('{a + 32'(k), st ? FUNCT3_SB : FUNCT3_LBU, st, {24'h0, sh[7:0]}});
                end
            end
            for (int k = 0; k < n; k++) begin
                sh = wd >> (8 * k);
                if (st) ref_mem[8'(a + 32'(k))] = sh[7:0];
                else    val[8*k +: 8] = ref_mem[8'(a + 32'(k))];
            end
            if (!st) begin
                case (f3)
                    FUNCT3_LB: rd = {{24{val[7]}}, val[7:0]};
                    FUNCT3_LH: rd = {{16{val[15]}}, val[15:0]};
                    default:   rd = val;
                endcase
            end
        end
    endtask

    task automatic test_reset;
        #2 rst = 1'b0;
        #1;
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b want=1", req_ready); end
        checks++; if ({resp_valid, resp_err} !== 2'b00) begin errors++; $display("FAIL reset_resp got=%b want=00", {resp_valid, resp_err}); end
        checks++; if ({mem_read_en, mem_write_en} !== 2'b00) begin errors++; $display("FAIL reset_en got=%b want=00", {mem_read_en, mem_write_en}); end
        checks++; if ({mem_addr, mem_wdata, mem_funct3, resp_rdata} !== '0) begin
            errors++; $display("FAIL reset_outputs addr=%h wdata=%h f3=%h rdata=%h want all 0", mem_addr, mem_wdata, mem_funct3, resp_rdata);
        end
    endtask

    task automatic test_aligned_lw;
        int lat, st;
        logic [31:0] rd;
        logic er;
        run_op(1'b0, FUNCT3_LW, BASE_ADDR + 32'h4, 32'h0, lat, rd, er, st);
        checks++; if (lat != 2) begin errors++; $display("FAIL lw_latency got=%0d want=2", lat); end
        checks++; if (rd !== 32'h1122_3344 || er !== 1'b0) begin errors++; $display("FAIL lw_data got=%h err=%b want=11223344 err=0", rd, er); end
        checks++; if (acc_q.size() - st != 1 || acc_q[st].addr !== BASE_ADDR + 32'h4 || acc_q[st].f3 !== FUNCT3_LW || acc_q[st].we !== 1'b0) begin
            errors++; $display("FAIL lw_access count=%0d want one LW read at %h", acc_q.size() - st, BASE_ADDR + 32'h4);
        end
    endtask

    task automatic test_split_sw;
        int lat, st;
        logic [31:0] rd;
        logic er;
        logic [7:0] exp_b [4];
        exp_b = '{8'hDD, 8'hCC, 8'hBB, 8'hAA};
        run_op(1'b1, FUNCT3_SW, BASE_ADDR + 32'h1, 32'hAABB_CCDD, lat, rd, er, st);
        checks++; if (lat != 5 || er !== 1'b0 || rd !== 32'h0) begin errors++; $display("FAIL sw_split_resp lat=%0d err=%b rdata=%h want 5 0 0", lat, er, rd); end
        checks++; if (acc_q.size() - st != 4) begin errors++; $display("FAIL sw_split_count got=%0d want=4", acc_q.size() - st); end
        else for (int k = 0; k < 4; k++) begin
            checks++;
            if (acc_q[st+k].addr !== BASE_ADDR + 32'(k + 1) || acc_q[st+k].f3 !== FUNCT3_SB ||
                acc_q[st+k].we !== 1'b1 || acc_q[st+k].wdata !== {24'h0, exp_b[k]}) begin
                errors++; $display("FAIL sw_split_byte%0d addr=%h f3=%h we=%b wdata=%h want data %h", k,
                                   acc_q[st+k].addr, acc_q[st+k].f3, acc_q[st+k].we, acc_q[st+k].wdata, exp_b[k]);
            end
        end
        for (int k = 0; k < 4; k++) ref_mem[k + 1] = exp_b[k];
        run_op(1'b0, FUNCT3_LW, BASE_ADDR, 32'h0, lat, rd, er, st);
        checks++; if (rd !== {8'hBB, 8'hCC, 8'hDD, ref_mem[0]}) begin errors++; $display("FAIL sw_readback got=%h want=%h", rd, {8'hBB, 8'hCC, 8'hDD, ref_mem[0]}); end
    endtask

    task automatic test_split_lh;
        int lat, st;
        logic [31:0] rd;
        logic er;
        poke(8'h03, 8'h80);
        poke(8'h04, 8'hFF);
        run_op(1'b0, FUNCT3_LH, BASE_ADDR + 32'h3, 32'h0, lat, rd, er, st);
        checks++; if (lat != 3 || rd !== 32'hFFFF_FF80) begin errors++; $display("FAIL lh_split lat=%0d rdata=%h want 3 ffffff80", lat, rd); end
        checks++; if (acc_q.size() - st != 2 || acc_q[st].f3 !== FUNCT3_LBU || acc_q[st+1].addr !== BASE_ADDR + 32'h4) begin
            errors++; $display("FAIL lh_split_access count=%0d want two LBU reads", acc_q.size() - st);
        end
        run_op(1'b0, FUNCT3_LHU, BASE_ADDR + 32'h3, 32'h0, lat, rd, er, st);
        checks++; if (lat != 3 || rd !== 32'h0000_FF80) begin errors++; $display("FAIL lhu_split lat=%0d rdata=%h want 3 0000ff80", lat, rd); end
    endtask

    task automatic test_illegal;
        int lat, st;
        logic [31:0] rd;
        logic er;
        run_op(1'b0, 3'b011, BASE_ADDR + 32'h8, 32'h0, lat, rd, er, st);
        checks++; if (lat != 1 || er !== 1'b1 || rd !== 32'h0) begin errors++; $display("FAIL illegal_load lat=%0d err=%b rdata=%h want 1 1 0", lat, er, rd); end
        checks++; if (acc_q.size() != st) begin errors++; $display("FAIL illegal_load_mem accesses=%0d want=0", acc_q.size() - st); end
        run_op(1'b1, FUNCT3_LBU, BASE_ADDR + 32'h8, 32'h1234, lat, rd, er, st);
        checks++; if (lat != 1 || er !== 1'b1 || acc_q.size() != st) begin errors++; $display("FAIL illegal_store lat=%0d err=%b accesses=%0d want 1 1 0", lat, er, acc_q.size() - st); end
    endtask

    task automatic ns_op(input logic [31:0] a, output int lat, output logic er, output logic [31:0] rd, output logic saw_en);
        lat = -1; er = 1'b0; rd = '0; saw_en = 1'b0;
        @(negedge clk);
        ns_valid = 1'b1; ns_f3 = FUNCT3_LW; ns_addr = a;
        @(posedge clk); #1;
        ns_valid = 1'b0;
        for (int n = 1; n <= 6; n++) begin
            @(negedge clk);
            if (ns_rd || ns_wr) saw_en = 1'b1;
            if (ns_resp_valid && lat < 0) begin lat = n; er = ns_resp_err; rd = ns_rdata; end
        end
    endtask

    task automatic test_no_split;
        int lat;
        logic er, saw_en;
        logic [31:0] rd;
        ns_op(BASE_ADDR + 32'h1, lat, er, rd, saw_en);
        checks++; if (lat != 1 || er !== 1'b1 || saw_en !== 1'b0) begin errors++; $display("FAIL nosplit_misaligned lat=%0d err=%b enable_seen=%b want 1 1 0", lat, er, saw_en); end
        ns_op(BASE_ADDR + 32'h4, lat, er, rd, saw_en);
        checks++; if (lat != 2 || er !== 1'b0 || rd !== 32'h5A5A_5A5A || saw_en !== 1'b1) begin
            errors++; $display("FAIL nosplit_aligned lat=%0d err=%b rdata=%h want 2 0 5a5a5a5a", lat, er, rd);
        end
    endtask

    task automatic test_back_to_back;
        int accepts, resp0;
        logic exp_rdy;
        accepts = 0;
        resp0 = resp_cnt;
        @(negedge clk);
        req_valid = 1'b1; req_is_store = 1'b0; req_funct3 = FUNCT3_LW; req_addr = BASE_ADDR + 32'h8;
        for (int i = 0; i < 12; i++) begin
            exp_rdy = (i % 3 == 0);
            checks++; if (req_ready !== exp_rdy) begin errors++; $display("FAIL b2b_ready cycle=%0d got=%b want=%b", i, req_ready, exp_rdy); end
            if (req_ready) accepts++;
            @(negedge clk);
        end
        req_valid = 1'b0;
        @(negedge clk);
        checks++; if (accepts != 4 || resp_cnt - resp0 != 4) begin errors++; $display("FAIL b2b_count accepts=%0d resps=%0d want 4 4", accepts, resp_cnt - resp0); end
    endtask

    task automatic test_reset_mid_split;
        int resp0;
        for (int k = 8'h21; k <= 8'h24; k++) poke(8'(k), 8'h00);
        @(negedge clk);
        req_valid = 1'b1; req_is_store = 1'b1; req_funct3 = FUNCT3_SW;
        req_addr = BASE_ADDR + 32'h21; req_wdata = 32'h4433_2211;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        resp0 = resp_cnt;
        rst = 1'b0;
        #1;
        checks++; if ({mem_read_en, mem_write_en} !== 2'b00 || req_ready !== 1'b1 || resp_valid !== 1'b0) begin
            errors++; $display("FAIL midsplit_reset en=%b ready=%b resp=%b want 00 1 0", {mem_read_en, mem_write_en}, req_ready, resp_valid);
        end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (resp_cnt != resp0) begin errors++; $display("FAIL midsplit_resp got=%0d want=0", resp_cnt - resp0); end
        checks++; if ({mem[8'h21], mem[8'h22], mem[8'h23], mem[8'h24]} !== 32'h1100_0000) begin
            errors++; $display("FAIL midsplit_mem got=%h want=11000000", {mem[8'h21], mem[8'h22], mem[8'h23], mem[8'h24]});
        end
        ref_mem[8'h21] = 8'h11;
    endtask

    task automatic test_random;
        int lat, elat, st;
        logic [31:0] rd, erd, a, wd;
        logic er, eer, s;
        logic [2:0] f3;
        for (int t = 0; t < 60; t++) begin
            s  = 1'($urandom_range(0, 1));
            f3 = 3'($urandom_range(0, 7));
            a  = BASE_ADDR + 32'($urandom_range(0, 60));
            wd = $urandom;
            model_op(s, f3, a, wd, elat, erd, eer);
            run_op(s, f3, a, wd, lat, rd, er, st);
            checks++; if (lat != elat || er !== eer || rd !== erd) begin
                errors++; $display("FAIL rand%0d_resp st=%b f3=%0d addr=%h lat=%0d err=%b rdata=%h want %0d %b %h", t, s, f3, a, lat, er, rd, elat, eer, erd);
            end
            checks++; if (acc_q.size() - st != exp_q.size()) begin
                errors++; $display("FAIL rand%0d_count got=%0d want=%0d", t, acc_q.size() - st, exp_q.size());
            end else for (int k = 0; k < exp_q.size(); k++) begin
                checks++;
                if (acc_q[st+k].addr !== exp_q[k].addr || acc_q[st+k].f3 !== exp_q[k].f3 || acc_q[st+k].we !== exp_q[k].we ||
                    (exp_q[k].we && acc_q[st+k].wdata !== exp_q[k].wdata)) begin
                    errors++; $display("FAIL rand%0d_acc%0d got=%h/%0d/%b/%h want=%h/%0d/%b/%h", t, k, acc_q[st+k].addr, acc_q[st+k].f3,
                                       acc_q[st+k].we, acc_q[st+k].wdata, exp_q[k].addr, exp_q[k].f3, exp_q[k].we, exp_q[k].wdata);
                end
            end
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset;
        for (int k = 0; k < 256; k++) poke(8'(k), 8'($urandom));
        poke(8'h04, 8'h44); poke(8'h05, 8'h33); poke(8'h06, 8'h22); poke(8'h07, 8'h11);
        @(negedge clk);
        rst = 1'b1;
        test_aligned_lw;
        test_split_sw;
        test_split_lh;
        test_illegal;
        test_no_split;
        test_back_to_back;
        test_reset_mid_split;
        test_random;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
